// File: rtl/merger_4.sv
// merger_4: one 2-to-1 stage of a streaming merge tree. Merges two sorted
// streams of 4-key tuples (32-bit unsigned keys, lane 0 smallest) into one
// sorted stream, one tuple per cycle, with zero latency. A 4-key feedback
// register holds the upper half of the last merge so that each output
// tuple is guaranteed to be the 4 smallest keys not yet emitted.
module merger_4 (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_fifo_1,
  input  logic         i_fifo_1_empty,
  input  logic [127:0] i_fifo_2,
  input  logic         i_fifo_2_empty,
  input  logic         i_fifo_out_ready,
  output logic         o_fifo_1_read,
  output logic         o_fifo_2_read,
  output logic         o_out_fifo_write,
  output logic [127:0] o_data
);

  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int TUPLE_W = DATA_W * LANES;
  localparam int NET_W   = 2 * LANES;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] r_keys [LANES];

  logic              sel_1;
  logic              fire;
  logic [TUPLE_W-1:0] head;

  logic [DATA_W-1:0] net_in [NET_W];
  logic [DATA_W-1:0] st1    [NET_W];
  logic [DATA_W-1:0] st2    [NET_W];
  logic [DATA_W-1:0] st3    [NET_W];

  function automatic logic [DATA_W-1:0] key_min(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a <= b) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] key_max(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a <= b) ? b : a;
  endfunction

  // Pick the stream with the smaller head key (FIFO 1 wins ties) and decide
  // whether this cycle may consume it. Reset suppresses all activity.
  always_comb begin
    sel_1 = (i_fifo_1[DATA_W-1:0] <= i_fifo_2[DATA_W-1:0]);
    head  = sel_1 ? i_fifo_1 : i_fifo_2;
    fire  = ~i_rst & ~i_fifo_1_empty & ~i_fifo_2_empty &
            ((state == LOAD) | i_fifo_out_ready);
  end

  // Bitonic merge of R (ascending) with the reversed head tuple: the
  // 8-key input is bitonic, so three half-cleaner layers sort it fully.
  always_comb begin
    net_in = '{default: '0};
    st1    = '{default: '0};
    st2    = '{default: '0};
    st3    = '{default: '0};

    for (int i = 0; i < LANES; i++) begin
      net_in[i]         = r_keys[i];
      net_in[LANES + i] = head[(LANES-1-i)*DATA_W +: DATA_W];
    end

    // distance-4 compare/exchange
    for (int i = 0; i < LANES; i++) begin
      st1[i]         = key_min(net_in[i], net_in[i + LANES]);
      st1[i + LANES] = key_max(net_in[i], net_in[i + LANES]);
    end

    // distance-2 compare/exchange within each half
    for (int h = 0; h < NET_W; h += LANES) begin
      for (int i = 0; i < 2; i++) begin
        st2[h + i]     = key_min(st1[h + i], st1[h + i + 2]);
        st2[h + i + 2] = key_max(st1[h + i], st1[h + i + 2]);
      end
    end

    // distance-1 compare/exchange on adjacent pairs
    for (int p = 0; p < LANES; p++) begin
      st3[2*p]     = key_min(st2[2*p], st2[2*p + 1]);
      st3[2*p + 1] = key_max(st2[2*p], st2[2*p + 1]);
    end
  end

  // Strobes and output tuple; o_data is held at zero unless written.
  always_comb begin
    o_fifo_1_read    = fire & sel_1;
    o_fifo_2_read    = fire & ~sel_1;
    o_out_fifo_write = fire & (state == RUN);
    o_data           = '0;
    if (o_out_fifo_write) begin
      for (int i = 0; i < LANES; i++) begin
        o_data[i*DATA_W +: DATA_W] = st3[i];
      end
    end
  end

  // Control FSM and feedback register: LOAD primes R, RUN keeps the high half.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= LOAD;
      for (int i = 0; i < LANES; i++) begin
        r_keys[i] <= '0;
      end
    end else if (fire) begin
      if (state == LOAD) begin
        for (int i = 0; i < LANES; i++) begin
          r_keys[i] <= head[i*DATA_W +: DATA_W];
        end
        state <= RUN;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          r_keys[i] <= st3[i + LANES];
        end
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_merger_4.sv
// Bench for merger_4: models the two show-ahead input FIFOs as queues,
// pushes hand-computed expected output tuples into a scoreboard queue, and
// a monitor pops/compares on every output write.
module tb_merger_4;

  logic         clk;
  logic         rst;
  logic [127:0] fifo_1;
  logic         fifo_1_empty;
  logic [127:0] fifo_2;
  logic         fifo_2_empty;
  logic         out_ready;
  logic         fifo_1_read;
  logic         fifo_2_read;
  logic         out_write;
  logic [127:0] data;

  logic [127:0] q1  [$];
  logic [127:0] q2  [$];
  logic [127:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  merger_4 dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_fifo_1         (fifo_1),
    .i_fifo_1_empty   (fifo_1_empty),
    .i_fifo_2         (fifo_2),
    .i_fifo_2_empty   (fifo_2_empty),
    .i_fifo_out_ready (out_ready),
    .o_fifo_1_read    (fifo_1_read),
    .o_fifo_2_read    (fifo_2_read),
    .o_out_fifo_write (out_write),
    .o_data           (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] tup(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  task automatic refresh();
    fifo_1_empty = (q1.size() == 0);
    fifo_2_empty = (q2.size() == 0);
    fifo_1 = fifo_1_empty ? 128'd0 : q1[0];
    fifo_2 = fifo_2_empty ? 128'd0 : q2[0];
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  // External FIFO model: pop at the edge where the DUT strobes a read.
  always @(posedge clk) begin
    logic p1, p2;
    p1 = fifo_1_read;
    p2 = fifo_2_read;
    #1;
    if (p1 && q1.size() != 0) void'(q1.pop_front());
    if (p2 && q2.size() != 0) void'(q2.pop_front());
    refresh();
  end

  // Scoreboard monitor plus per-cycle strobe invariants.
  always @(negedge clk) begin
    chk("one_read_max", {127'd0, fifo_1_read & fifo_2_read}, 128'd0);
    chk("read_when_empty",
        {126'd0, fifo_1_read & fifo_1_empty, fifo_2_read & fifo_2_empty}, 128'd0);
    if (out_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", data, 128'd0);
        errors++;
        $display("FAIL write_without_expectation got %h want none", data);
      end else begin
        chk("out_data", data, exp_q.pop_front());
      end
    end else begin
      chk("data_zero_idle", data, 128'd0);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    chk({name, "_rd1"}, {127'd0, fifo_1_read}, 128'd0);
    chk({name, "_rd2"}, {127'd0, fifo_2_read}, 128'd0);
    chk({name, "_wr"},  {127'd0, out_write},   128'd0);
    chk({name, "_data"}, data, 128'd0);
  endtask

  task automatic check_strobes(input string name, input logic r1, input logic r2, input logic w);
    @(negedge clk);
    chk({name, "_rd1"}, {127'd0, fifo_1_read}, {127'd0, r1});
    chk({name, "_rd2"}, {127'd0, fifo_2_read}, {127'd0, r2});
    chk({name, "_wr"},  {127'd0, out_write},   {127'd0, w});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    refresh();

    // Reset with both FIFOs loaded: everything must stay quiet.
    q1.push_back(tup(1, 3, 5, 7));   q1.push_back(tup(9, 11, 13, 15));
    q2.push_back(tup(2, 4, 6, 8));   q2.push_back(tup(10, 12, 14, 16));
    refresh();
    check_idle("reset");
    next_cycle();
    check_idle("reset2");
    next_cycle();
    rst = 1'b0;

    // Basic merge: LOAD pops FIFO 1, then [1,2,3,4], [5,6,7,8], then stall.
    exp_q.push_back(tup(1, 2, 3, 4));
    exp_q.push_back(tup(5, 6, 7, 8));
    check_strobes("load", 1'b1, 1'b0, 1'b0);
    next_cycle();
    check_strobes("run1", 1'b0, 1'b1, 1'b1);
    repeat (3) next_cycle();
    chk("basic_drained", exp_q.size(), 0);
    chk("basic_q1", q1.size(), 0);
    chk("basic_q2", q2.size(), 1);
    check_idle("basic_stall");
    next_cycle();

    // Continuation: R=[9,11,13,15] merges with the new tuples.
    q1.push_back(tup(17, 19, 21, 23)); q1.push_back(tup(25, 26, 27, 28));
    q2.push_back(tup(18, 20, 22, 24));
    exp_q.push_back(tup(9, 10, 11, 12));
    exp_q.push_back(tup(13, 14, 15, 16));
    exp_q.push_back(tup(17, 18, 19, 20));
    refresh();
    repeat (5) next_cycle();
    chk("cont_drained", exp_q.size(), 0);
    chk("cont_q1", q1.size(), 1);
    chk("cont_q2", q2.size(), 0);

    // FIFO 2 empty, FIFO 1 non-empty: no strobes, zero data.
    check_idle("empty2");
    next_cycle();
    check_idle("empty2b");
    next_cycle();

    // Backpressure: both non-empty, ready low for 3 cycles.
    out_ready = 1'b0;
    q2.push_back(tup(30, 31, 32, 33));
    q1.push_back(tup(34, 35, 36, 37));
    refresh();
    check_idle("bp1"); next_cycle();
    check_idle("bp2"); next_cycle();
    check_idle("bp3"); next_cycle();
    chk("bp_q1_held", q1.size(), 2);
    chk("bp_q2_held", q2.size(), 1);
    out_ready = 1'b1;
    exp_q.push_back(tup(21, 22, 23, 24));
    exp_q.push_back(tup(25, 26, 27, 28));
    check_strobes("bp_resume", 1'b1, 1'b0, 1'b1);
    repeat (4) next_cycle();
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_q1_after", q1.size(), 1);

    // Reset mid-run: R contents are discarded, merge restarts from LOAD.
    rst = 1'b1;
    q1.delete(); q2.delete();
    refresh();
    next_cycle();
    rst = 1'b0;
    q1.push_back(tup(1, 3, 5, 7));   q1.push_back(tup(9, 11, 13, 15));
    q2.push_back(tup(2, 4, 6, 8));   q2.push_back(tup(10, 12, 14, 16));
    exp_q.push_back(tup(1, 2, 3, 4));
    refresh();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    check_idle("mid_reset");
    next_cycle();
    rst = 1'b0;
    exp_q.push_back(tup(9, 10, 11, 12));
    q1.push_back(tup(17, 19, 21, 23));
    refresh();
    check_strobes("post_reset_load", 1'b1, 1'b0, 1'b0);
    repeat (3) next_cycle();
    chk("post_reset_drained", exp_q.size(), 0);
    chk("post_reset_q2", q2.size(), 0);

    // Tie on head keys: FIFO 1 must win every time.
    rst = 1'b1;
    q1.delete(); q2.delete();
    refresh();
    next_cycle();
    rst = 1'b0;
    q1.push_back(tup(5, 5, 5, 5)); q1.push_back(tup(5, 5, 5, 5));
    q2.push_back(tup(5, 5, 5, 5));
    exp_q.push_back(tup(5, 5, 5, 5));
    refresh();
    check_strobes("tie_load", 1'b1, 1'b0, 1'b0);
    next_cycle();
    check_strobes("tie_run", 1'b1, 1'b0, 1'b1);
    repeat (2) next_cycle();
    chk("tie_drained", exp_q.size(), 0);
    chk("tie_q2_kept", q2.size(), 1);

    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merger_4.md
# merger_4

Streaming 2-to-1 merge unit for 4-wide tuples of 32-bit unsigned keys, one stage of the merge tree. It consumes two sorted input streams from show-ahead FIFOs and produces one sorted output stream, 4 keys per cycle. It sits between two input FIFOs and one output FIFO.

## Interface
- No parameters. Tuple width is fixed at 4 lanes × 32 bits = 128 bits.
- Lane k of every tuple occupies bits [32k+31:32k]. Lane 0 holds the smallest key.
- Reset is synchronous and active-high. The design uses one clock.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_fifo_1  in  128  head tuple of input FIFO 1 (show-ahead; valid while not empty).
- i_fifo_1_empty  in  1  FIFO 1 has no tuple.
- i_fifo_2  in  128  head tuple of input FIFO 2.
- i_fifo_2_empty  in  1  FIFO 2 has no tuple.
- i_fifo_out_ready  in  1  output FIFO accepts a write this cycle.
- o_fifo_1_read  out  1  pop FIFO 1 at this edge.
- o_fifo_2_read  out  1  pop FIFO 2 at this edge.
- o_out_fifo_write  out  1  o_data is written to the output FIFO at this edge.
- o_data  out  128  sorted output tuple.

## Operation
- Input contract:
  - Each input stream is non-decreasing within a tuple (lane 0 ≤ lane 3).
  - Each input stream is non-decreasing across tuples.
  - Keys are compared as unsigned 32-bit values.
- Internal state:
  - Feedback register R holds 4 keys, sorted ascending.
  - State machine has two states: LOAD and RUN.
- Selection:
  - sel = FIFO 1 if i_fifo_1[31:0] ≤ i_fifo_2[31:0], else FIFO 2.
  - On ties, FIFO 1 wins.
- Fire condition:
  - fire = ~i_fifo_1_empty & ~i_fifo_2_empty & (state==LOAD | i_fifo_out_ready).
  - Both inputs must be non-empty to fire.
  - There is no end-of-stream flush; keys remaining in R stay there until more input arrives.
- LOAD state:
  - On fire, pop the selected FIFO and load R with its head tuple.
  - No output write.
  - Go to RUN.
- RUN state:
  - On fire, pop the selected FIFO.
  - Apply an 8-key sorting/bitonic merge network to {R, selected head}.
  - o_data = lowest 4 keys in ascending lane order; o_out_fifo_write = 1.
  - R ← highest 4 keys in ascending order.
  - Stay in RUN.
- The read strobes and the write strobe are combinational functions of current inputs and state:
  - o_fifo_1_read = fire & sel==1.
  - o_fifo_2_read = fire & sel==2.
  - o_out_fifo_write = fire & state==RUN.
- At most one read strobe is high per cycle. A read strobe is never asserted when the corresponding FIFO is empty.
- o_data is 0 whenever o_out_fifo_write is 0.
- No stall state is kept: when the fire condition is false, nothing changes.

## Timing
- Reset (i_rst high at an edge):
  - state ← LOAD, R ← 0.
  - Reset has priority over fire in the same cycle; no pop or write is credited.
  - While i_rst is high, all outputs are forced to 0.
- Latency: zero. An output tuple is produced combinationally in the same cycle its input is popped.
  - The merge network must be purely combinational.
- Throughput: one output tuple per cycle in steady state.
- Mid-stream reset discards R (up to 4 keys); the external FIFOs are not affected.
- i_fifo_out_ready low in RUN:
  - No pops, no write; R holds.
  - Resumes on the first cycle it returns high.
- One input empty: stall until both are non-empty, in either state.

## Test plan
- Reset, then FIFO1 = [1,3,5,7],[9,11,13,15] and FIFO2 = [2,4,6,8],[10,12,14,16], ready=1. Required response:
  - Cycle 1: LOAD pops FIFO1, no write.
  - Next cycle: pops FIFO2, writes [1,2,3,4].
  - Next cycle: pops FIFO1, writes [5,6,7,8].
  - Then stall with R=[9,11,13,15].
- Continue the first scenario by adding [17,19,21,23] to FIFO1 and [18,20,22,24] to FIFO2. Required output sequence: [9,10,11,12], [13,14,15,16], [17,18,19,20]; R=[21,22,23,24].
- Tie: both heads [5,5,5,5] → FIFO1 is popped first. Output is all 5s. o_fifo_2_read stays low during the tie cycle.
- Backpressure: hold i_fifo_out_ready=0 in RUN for 3 cycles with both FIFOs non-empty. Required: no reads or writes during those cycles, R unchanged. Output resumes identical to the no-stall run.
- Empty input: FIFO2 empty with FIFO1 full → no strobes and o_data=0.
- Reset mid-run: i_rst asserted after the first output.
  - Required: next cycle in LOAD, R=0, outputs 0.
  - Subsequent data is merged as if from power-up.
